psu_ucseq: RTL
==============

PSU_UCSEQ -- requirements
Module: psu_ucseq

Interface
REQ-001 The block SHALL have parameter NUM_UCC, default 4, meaning the number of unit-cell controller lanes stepped in parallel.
REQ-002 The block SHALL have parameter NUM_UCROW, default 4, meaning the unit-cell grid rows.
REQ-003 The block SHALL have parameter NUM_UCCOL, default 4, meaning the unit-cell grid columns.
REQ-004 The block SHALL have parameter UCADDR_BW, default 4, meaning the per-lane unit-cell index width, at least clog2(NUM_UCROW*NUM_UCCOL).
REQ-005 The block SHALL have parameter OPCODE_BW, default 4, meaning the opcode width.
REQ-006 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-007 Port clk, input, 1 bit: the clock.
REQ-008 Port rst_n, input, 1 bit: the asynchronous active-low reset.
REQ-009 Port start, input, 1 bit: request to sweep the grid with opcode_in.
REQ-010 Port opcode_in, input, OPCODE_BW bits: the opcode to run for the sweep.
REQ-011 Port step_rdy, input, 1 bit: the downstream PCUs accept the current batch this cycle.
REQ-012 Port abort, input, 1 bit: abandon the sweep in progress.
REQ-013 Port opcode_running, output, OPCODE_BW bits: the latched opcode.
REQ-014 Port uc_counter, output, NUM_UCC*UCADDR_BW bits: the per-lane unit-cell index, lane i at [i*UCADDR_BW +: UCADDR_BW].
REQ-015 Port ucc_valid, output, NUM_UCC bits: per-lane flag, set when the lane index is below NUM_UC.
REQ-016 Port busy, output, 1 bit: a sweep is in progress.
REQ-017 Port batch_last, output, 1 bit: the current batch is the final batch.
REQ-018 Port done, output, 1 bit: one-cycle pulse when a sweep completes.

Function
REQ-019 NUM_UC SHALL equal NUM_UCROW*NUM_UCCOL, and a sweep SHALL consist of NBATCH = ceil(NUM_UC/NUM_UCC) batches.
REQ-020 The FSM SHALL have states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-021 In IDLE, start=1 SHALL latch opcode_in into opcode_running, set the base counter to 0 and move to RUN on the next clock edge.
REQ-022 In IDLE, start=0 SHALL hold all registers.
REQ-023 The base counter SHALL be UCADDR_BW+1 bits wide so that base+NUM_UCC never wraps.
REQ-024 In RUN, uc_counter lane i SHALL equal base+i truncated to UCADDR_BW bits when ucc_valid[i]=1, and 0 otherwise.
REQ-025 In RUN, ucc_valid[i] SHALL equal (base+i < NUM_UC); batch_last SHALL equal (base+NUM_UCC >= NUM_UC).
REQ-026 uc_counter, ucc_valid and batch_last SHALL be 0 outside RUN.
REQ-027 In RUN, with step_rdy=1 and batch_last=0, base SHALL advance by NUM_UCC.
REQ-028 In RUN, with step_rdy=1 and batch_last=1, the FSM SHALL move to DONE.
REQ-029 In RUN, step_rdy=0 SHALL hold base and all outputs (stall) with no cycle limit.
REQ-030 Each batch SHALL be presented for at least one cycle, and the batch-advance latency from step_rdy SHALL be 1 clock.
REQ-031 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-032 start SHALL be ignored in DONE; a sweep starts no earlier than the cycle after done.
REQ-033 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-034 start SHALL be ignored while busy=1, and opcode_running SHALL be stable from the RUN entry until the next accepted start.
REQ-035 abort=1 in RUN SHALL force IDLE on the next edge with no done pulse; abort SHALL have priority over step_rdy.
REQ-036 opcode_running SHALL keep its value after abort.
REQ-037 abort in IDLE or DONE SHALL have no effect; done still pulses in DONE.
REQ-038 A minimum sweep (NBATCH=1, step_rdy held 1) SHALL give start, then RUN for 1 cycle, then done, then IDLE.
REQ-039 A sweep with step_rdy held 1 SHALL take NBATCH+2 cycles from accepted start to the return to IDLE.

Reset
REQ-040 rst_n=0 SHALL asynchronously force IDLE, with base=0, opcode_running=0, uc_counter=0, ucc_valid=0, busy=0, batch_last=0 and done=0.
REQ-041 Reset asserted mid-sweep SHALL cancel the sweep with no done pulse, and deassertion SHALL resume in IDLE.

Verification
REQ-042 4x4 grid, NUM_UCC=4, start with opcode_in=5, step_rdy=1: the bench SHALL see lane-0 counter values 0,4,8,12 on consecutive cycles, ucc_valid=4'b1111 throughout, batch_last only at base 12, done one cycle later, and opcode_running=5.
REQ-043 NUM_UCC=3, 4x4 grid: the bench SHALL see 6 batches, and the last batch SHALL have base 15, lane 0=15, ucc_valid=3'b001, and lanes 1 and 2 at 0.
REQ-044 step_rdy=0 for 3 cycles at base 4: the bench SHALL see uc_counter held for 3 cycles and a total sweep of 9 cycles.
REQ-045 abort at base 8: the bench SHALL see IDLE next cycle, busy=0, no done pulse, and opcode_running unchanged.
REQ-046 start pulsed in RUN with a different opcode: the bench SHALL see it ignored and opcode_running unchanged.
REQ-047 rst_n low mid-RUN asynchronously: the bench SHALL see all outputs 0 before the next clock edge, and start after release SHALL begin at base 0.

Source files
------------

// File: rtl/psu_ucseq.sv
// psu_ucseq: unit-cell sweep sequencer.
//
// Steps a grid of NUM_UCROW x NUM_UCCOL unit cells in batches of NUM_UCC lanes.
// A sweep is started with `start`. The opcode is latched on that start, and each
// batch is held until the downstream PCUs accept it with `step_rdy`. When the
// final batch is accepted, `done` pulses for one cycle. `abort` cancels a sweep
// without producing `done`.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   start           - request a sweep using opcode_in (ignored while busy)
//   opcode_in       - opcode for the sweep
//   step_rdy        - downstream accepts the current batch this cycle
//   abort           - abandon the running sweep (priority over step_rdy)
//   opcode_running  - opcode latched at the last accepted start
//   uc_counter      - per-lane unit-cell index, lane i at [i*UCADDR_BW +: UCADDR_BW]
//   ucc_valid       - per-lane flag, lane index lies inside the grid
//   busy            - sweep in progress (RUN or DONE)
//   batch_last      - current batch is the final one
//   done            - one-cycle pulse on sweep completion
module psu_ucseq #(
  parameter int unsigned NUM_UCC   = 4,
  parameter int unsigned NUM_UCROW = 4,
  parameter int unsigned NUM_UCCOL = 4,
  parameter int unsigned UCADDR_BW = 4,
  parameter int unsigned OPCODE_BW = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [OPCODE_BW-1:0]           opcode_in,
  input  logic                           step_rdy,
  input  logic                           abort,
  output logic [OPCODE_BW-1:0]           opcode_running,
  output logic [NUM_UCC*UCADDR_BW-1:0]   uc_counter,
  output logic [NUM_UCC-1:0]             ucc_valid,
  output logic                           busy,
  output logic                           batch_last,
  output logic                           done
);

  localparam int unsigned NUM_UC  = NUM_UCROW * NUM_UCCOL;
  // One spare bit so base + NUM_UCC cannot wrap on the final batch.
  localparam int unsigned BASE_BW = UCADDR_BW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [BASE_BW-1:0]     base_q, base_d;
  logic [OPCODE_BW-1:0]   opcode_q, opcode_d;
  logic                   last_batch;
  logic [31:0]            lane_idx;

  // Comparisons are done in 32 bits so the grid size never truncates.
  assign last_batch = (32'(base_q) + NUM_UCC) >= NUM_UC;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      base_q   <= '0;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      opcode_q <= opcode_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    opcode_d = opcode_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          opcode_d = opcode_in;
          base_d   = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (step_rdy) begin
          if (last_batch) begin
            state_d = StDone;
          end else begin
            base_d = base_q + BASE_BW'(NUM_UCC);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: decoded from the registered state only, so they clear as soon as reset asserts.
  always_comb begin
    uc_counter = '0;
    ucc_valid  = '0;
    batch_last = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    lane_idx   = '0;
    unique case (state_q)
      StRun: begin
        busy       = 1'b1;
        batch_last = last_batch;
        for (int unsigned i = 0; i < NUM_UCC; i++) begin
          lane_idx = 32'(base_q) + i;
          if (lane_idx < NUM_UC) begin
            ucc_valid[i]                          = 1'b1;
            uc_counter[i*UCADDR_BW +: UCADDR_BW]  = lane_idx[UCADDR_BW-1:0];
          end
        end
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign opcode_running = opcode_q;

endmodule
